// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl -- bit-serial ALU sequencer.
//
// Runs one WIDTH-bit AND/OR/ADD/SUB/SLT operation through a single 1-bit
// ALU slice, LSB first, one bit per clock. The Op/BInvert encoding is the
// same as the rippled datapath ALU.
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Start     in   request, sampled only in IDLE
//   A, B      in   WIDTH-bit operands, latched on accept
//   BInvert   in   invert B and force carry-in to 1, latched
//   Op        in   00 AND, 01 OR, 10 ADD/SUB, 11 SLT, latched
//   Busy      out  high from the accepting edge until Done
//   Done      out  one-cycle completion pulse
//   Result    out  WIDTH-bit result, held until the next completion
//   CarryOut  out  MSB carry-out (Op 1x only)
//   Overflow  out  signed overflow (Op 1x only)
//   Zero      out  Result == 0
//
// Optional feature macro: ALU_SERIAL_ZERO_EN (enables the Zero flag; when
// undefined, Zero is tied to 0).

module alu1 (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       binv_i,
  input  logic       cin_i,
  input  logic       less_i,
  input  logic [1:0] op_i,
  output logic       res_o,
  output logic       cout_o
);
  logic bb;
  assign bb     = b_i ^ binv_i;
  assign cout_o = (a_i & bb) | (cin_i & (a_i ^ bb));
  always_comb begin
    res_o = 1'b0;
    case (op_i)
      2'b00: res_o = a_i & bb;
      2'b01: res_o = a_i | bb;
      2'b10: res_o = a_i ^ bb ^ cin_i;
      2'b11: res_o = less_i;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BInvert,
  input  logic [1:0]       Op,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;   // running carry between bits
  logic             cmsb_q;    // carry into the MSB
  logic [WIDTH-1:0] a_q, b_q;  // operands, shifted right one bit per step
  logic             binv_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] sh_q;      // result assembly, filled from the MSB side
  logic [WIDTH-1:0] Result_q;
  logic             Busy_q, Done_q, CarryOut_q, Overflow_q;

  // Slice interface
  logic       s_res_d, s_cout_d;
  logic [1:0] s_op_d;
  logic       slt_d;

  // SLT runs the slice as a subtract; the compare bit is fixed up afterwards.
  assign s_op_d = (op_q == 2'b11) ? 2'b10 : op_q;
  assign slt_d  = sh_q[WIDTH-1] ^ cmsb_q ^ carry_q;

  alu1 u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .binv_i (binv_q),
    .cin_i  (carry_q),
    .less_i (1'b0),
    .op_i   (s_op_d),
    .res_o  (s_res_d),
    .cout_o (s_cout_d)
  );

`ifdef ALU_SERIAL_ZERO_EN
  logic acc_q;   // sticky OR of shifted-in result bits
  logic Zero_q;
  assign Zero = Zero_q;
`else
  assign Zero = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cmsb_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      binv_q     <= 1'b0;
      op_q       <= 2'b00;
      sh_q       <= '0;
      Result_q   <= '0;
      Busy_q     <= 1'b0;
      Done_q     <= 1'b0;
      CarryOut_q <= 1'b0;
      Overflow_q <= 1'b0;
`ifdef ALU_SERIAL_ZERO_EN
      acc_q      <= 1'b0;
      Zero_q     <= 1'b1;
`endif
    end else begin
      Done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            binv_q  <= BInvert;
            op_q    <= Op;
            cnt_q   <= '0;
            carry_q <= BInvert;
            Busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef ALU_SERIAL_ZERO_EN
            acc_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (cnt_q != CW'(WIDTH)) begin
            // One bit step
            sh_q    <= {s_res_d, sh_q[WIDTH-1:1]};
            carry_q <= s_cout_d;
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1))
              cmsb_q <= carry_q;
`ifdef ALU_SERIAL_ZERO_EN
            acc_q   <= acc_q | s_res_d;
`endif
          end else if (op_q == 2'b11) begin
            state_q <= SLTFIX;
          end else begin
            // Wrap-up cycle: publish the assembled result
            Result_q   <= sh_q;
            CarryOut_q <= op_q[1] & carry_q;
            Overflow_q <= op_q[1] & (cmsb_q ^ carry_q);
`ifdef ALU_SERIAL_ZERO_EN
            Zero_q     <= ~acc_q;
`endif
            Busy_q     <= 1'b0;
            Done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        SLTFIX: begin
          Result_q   <= {{(WIDTH-1){1'b0}}, slt_d};
          CarryOut_q <= carry_q;
          Overflow_q <= cmsb_q ^ carry_q;
`ifdef ALU_SERIAL_ZERO_EN
          Zero_q     <= ~slt_d;
`endif
          Busy_q     <= 1'b0;
          Done_q     <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy     = Busy_q;
  assign Done     = Done_q;
  assign Result   = Result_q;
  assign CarryOut = CarryOut_q;
  assign Overflow = Overflow_q;
endmodule
